mmio_timer: RTL and testbench

Memory-mapped machine timer that generalises the fixed mtime/mtimecmp pair to a configurable counter width, a programmable prescaler and `CHANNEL_COUNT` independent compare channels, each with its own interrupt. It sits on the core's data-memory bus beside block RAM and the USB buffer. It decodes its own address window and returns registered read data one cycle after the address is presented. `any_interrupt` drives the core's `mip_mtip` input.

---
 rtl/mmio_timer_pkg.sv | 68 ++++++
 rtl/timer_prescaler.sv | 29 ++
 rtl/mmio_timer.sv | 203 ++++++++++++++++++++
 tb/tb_mmio_timer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_timer_pkg.sv
// Shared register map, decode helpers and byte-lane merge for mmio_timer.
package mmio_timer_pkg;

    localparam logic [31:0] ADDRESS_BASE_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] WINDOW_MASK          = 32'hFFFF_FF80;

    // Byte offsets inside the 128-byte window; firmware headers mirror these.
    localparam logic [6:0] OFS_MTIME     = 7'h00;
    localparam logic [6:0] OFS_MTIMEH    = 7'h04;
    localparam logic [6:0] OFS_MTIMECMP  = 7'h08;
    localparam logic [6:0] OFS_MTIMECMPH = 7'h0C;
    localparam logic [6:0] OFS_CONTROL   = 7'h40;
    localparam logic [6:0] OFS_STATUS    = 7'h44;
    localparam int         CMP_STRIDE    = 8;
    localparam int         MAX_CHANNELS  = 4;

    localparam logic [4:0] WORD_MTIME     = OFS_MTIME[6:2];
    localparam logic [4:0] WORD_MTIMEH    = OFS_MTIMEH[6:2];
    localparam logic [4:0] WORD_CMP_FIRST = OFS_MTIMECMP[6:2];
    localparam logic [4:0] WORD_CMP_LAST  = 5'(WORD_CMP_FIRST + 5'(2 * MAX_CHANNELS - 1));
    localparam logic [4:0] WORD_CONTROL   = OFS_CONTROL[6:2];
    localparam logic [4:0] WORD_STATUS    = OFS_STATUS[6:2];

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MTIME_LO,
        SEL_MTIME_HI,
        SEL_CMP_LO,
        SEL_CMP_HI,
        SEL_CONTROL,
        SEL_STATUS
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e   sel;
        logic [1:0] channel;
    } reg_decode_t;

    // Maps a word index inside the window to a register kind and channel.
    function automatic reg_decode_t decode_word(input logic [4:0] word);
        reg_decode_t d;
        d.sel     = SEL_NONE;
        d.channel = 2'(word[3:1] - 3'd1);
        if (word == WORD_MTIME)
            d.sel = SEL_MTIME_LO;
        else if (word == WORD_MTIMEH)
            d.sel = SEL_MTIME_HI;
        else if (word >= WORD_CMP_FIRST && word <= WORD_CMP_LAST)
            d.sel = word[0] ? SEL_CMP_HI : SEL_CMP_LO;
        else if (word == WORD_CONTROL)
            d.sel = SEL_CONTROL;
        else if (word == WORD_STATUS)
            d.sel = SEL_STATUS;
        return d;
    endfunction

    // Replaces only the bytes whose lane enable is set.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_value,
                                                input logic [31:0] new_value,
                                                input logic [3:0]  lanes);
        logic [31:0] r;
        r = old_value;
        for (int b = 0; b < 4; b++)
            if (lanes[b]) r[8*b +: 8] = new_value[8*b +: 8];
        return r;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: count runs 0..divisor and ticks on the divisor value.
module timer_prescaler
    import mmio_timer_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk24,
    input  logic                      reset,
    input  logic [PRESCALE_WIDTH-1:0] divisor,
    input  logic                      enable,
    input  logic                      clear,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] count;

    assign tick = enable && (count == divisor);

    // Count advances only while enabled; a divisor change restarts the period.
    always_ff @(posedge clk24) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= tick ? '0 : count + PRESCALE_WIDTH'(1);
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped machine timer with prescaler and per-channel compare interrupts.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] ADDRESS_BASE   = ADDRESS_BASE_DEFAULT,
    parameter int          CHANNEL_COUNT  = 1,
    parameter int          COUNTER_WIDTH  = 64,
    parameter int          PRESCALE_WIDTH = 8
) (
    input  logic                     clk24,
    input  logic                     reset,
    input  logic [31:0]              memory_address,
    input  logic [31:0]              memory_write_value,
    input  logic [3:0]               memory_write_sections,
    output logic [31:0]              read_value,
    output logic                     read_valid,
    output logic [CHANNEL_COUNT-1:0] timer_interrupt,
    output logic                     any_interrupt
);

    logic                      hit;
    reg_decode_t               dec;
    logic                      write_en;

    logic [COUNTER_WIDTH-1:0]  mtime;
    logic [63:0]               mtime_wide;
    logic [63:0]               mtime_written;
    logic                      mtime_write;
    logic                      tick;

    logic                      count_enable;
    logic [CHANNEL_COUNT-1:0]  irq_enable;
    logic [PRESCALE_WIDTH-1:0] divisor;
    logic [31:0]               control_word;
    logic                      control_write;
    logic                      enable_written;
    logic [CHANNEL_COUNT-1:0]  irq_written;
    logic [PRESCALE_WIDTH-1:0] divisor_written;
    logic                      divisor_change;

    logic [63:0]               cmp_wide [CHANNEL_COUNT];
    logic [CHANNEL_COUNT-1:0]  match;
    logic [CHANNEL_COUNT-1:0]  status;
    logic [CHANNEL_COUNT-1:0]  status_clear;
    logic                      status_write;
    logic [31:0]               read_next;

    assign hit      = (memory_address & WINDOW_MASK) == ADDRESS_BASE;
    assign dec      = decode_word(memory_address[6:2]);
    assign write_en = hit && (memory_write_sections != 4'b0000);

    // ---------------- counter ----------------
    assign mtime_wide  = 64'(mtime);
    assign mtime_write = write_en && (dec.sel == SEL_MTIME_LO || dec.sel == SEL_MTIME_HI);

    // Byte-lane merge of a bus write into the zero-extended counter view.
    always_comb begin
        mtime_written = mtime_wide;
        if (dec.sel == SEL_MTIME_LO)
            mtime_written[31:0] = merge_lanes(mtime_wide[31:0], memory_write_value, memory_write_sections);
        else if (dec.sel == SEL_MTIME_HI)
            mtime_written[63:32] = merge_lanes(mtime_wide[63:32], memory_write_value, memory_write_sections);
    end

    // A bus write owns the counter for that cycle, so the tick is dropped.
    always_ff @(posedge clk24) begin
        if (reset)
            mtime <= '0;
        else if (mtime_write)
            mtime <= COUNTER_WIDTH'(mtime_written);
        else if (tick)
            mtime <= mtime + COUNTER_WIDTH'(1);
    end

    // ---------------- control / prescaler ----------------
    assign control_write   = write_en && dec.sel == SEL_CONTROL;
    assign enable_written  = 1'(merge_lanes(32'(count_enable), memory_write_value, memory_write_sections));
    assign irq_written     = CHANNEL_COUNT'(merge_lanes(32'(irq_enable) << 4, memory_write_value,
                                                        memory_write_sections) >> 4);
    assign divisor_written = PRESCALE_WIDTH'(merge_lanes(32'(divisor) << 8, memory_write_value,
                                                         memory_write_sections) >> 8);
    assign divisor_change  = control_write && (divisor_written != divisor);

    // Assembles the CONTROL register image for reads.
    always_comb begin
        control_word                       = '0;
        control_word[0]                    = count_enable;
        control_word[4 +: CHANNEL_COUNT]   = irq_enable;
        control_word[8 +: PRESCALE_WIDTH]  = divisor;
    end

    // Control fields; reset leaves the counter running with all interrupts enabled.
    always_ff @(posedge clk24) begin
        if (reset) begin
            count_enable <= 1'b1;
            irq_enable   <= '1;
            divisor      <= '0;
        end else if (control_write) begin
            count_enable <= enable_written;
            irq_enable   <= irq_written;
            divisor      <= divisor_written;
        end
    end

    timer_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clk24   (clk24),
        .reset   (reset),
        .divisor (divisor),
        .enable  (count_enable),
        .clear   (divisor_change),
        .tick    (tick)
    );

    // ---------------- compare channels ----------------
    assign status_write = write_en && dec.sel == SEL_STATUS;
    assign status_clear = status_write
                        ? CHANNEL_COUNT'(merge_lanes(32'd0, memory_write_value, memory_write_sections))
                        : '0;

    for (genvar i = 0; i < CHANNEL_COUNT; i++) begin : g_channel
        logic [COUNTER_WIDTH-1:0] mtimecmp;
        logic [63:0]              cmp_written;
        logic                     cmp_write_lo;
        logic                     cmp_write_hi;
        logic                     reached;
        logic                     match_q;
        logic                     status_q;

        assign cmp_wide[i]  = 64'(mtimecmp);
        assign cmp_write_lo = write_en && dec.sel == SEL_CMP_LO && int'(dec.channel) == i;
        assign cmp_write_hi = write_en && dec.sel == SEL_CMP_HI && int'(dec.channel) == i;
        assign reached      = mtime >= mtimecmp;

        // Byte-lane merge of a bus write into this channel's compare value.
        always_comb begin
            cmp_written = cmp_wide[i];
            if (cmp_write_lo)
                cmp_written[31:0] = merge_lanes(cmp_wide[i][31:0], memory_write_value, memory_write_sections);
            else if (cmp_write_hi)
                cmp_written[63:32] = merge_lanes(cmp_wide[i][63:32], memory_write_value, memory_write_sections);
        end

        // Compare value; all-ones at reset keeps the channel quiet until programmed.
        always_ff @(posedge clk24) begin
            if (reset)
                mtimecmp <= '1;
            else if (cmp_write_lo || cmp_write_hi)
                mtimecmp <= COUNTER_WIDTH'(cmp_written);
        end

        // Registered match and sticky flag; a rising match beats a same-cycle clear.
        always_ff @(posedge clk24) begin
            if (reset) begin
                match_q  <= 1'b0;
                status_q <= 1'b0;
            end else begin
                match_q  <= reached;
                status_q <= (reached && !match_q) || (status_q && !status_clear[i]);
            end
        end

        assign match[i]  = match_q;
        assign status[i] = status_q;
    end

    assign timer_interrupt = match & irq_enable;
    assign any_interrupt   = |timer_interrupt;

    // ---------------- read path ----------------
    // Read mux over current register state, i.e. before this cycle's write.
    always_comb begin
        read_next = '0;
        case (dec.sel)
            SEL_MTIME_LO: read_next = mtime_wide[31:0];
            SEL_MTIME_HI: read_next = mtime_wide[63:32];
            SEL_CMP_LO: begin
                for (int c = 0; c < CHANNEL_COUNT; c++)
                    if (int'(dec.channel) == c) read_next = cmp_wide[c][31:0];
            end
            SEL_CMP_HI: begin
                for (int c = 0; c < CHANNEL_COUNT; c++)
                    if (int'(dec.channel) == c) read_next = cmp_wide[c][63:32];
            end
            SEL_CONTROL:  read_next = control_word;
            SEL_STATUS:   read_next = 32'(status);
            default:      read_next = '0;
        endcase
    end

    // One-cycle registered read response for any access hitting the window.
    always_ff @(posedge clk24) begin
        if (reset) begin
            read_value <= '0;
            read_valid <= 1'b0;
        end else begin
            read_value <= hit ? read_next : 32'd0;
            read_valid <= hit;
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Randomized and directed bench for mmio_timer against a register-level model.
module tb_mmio_timer;

    localparam int          CH   = 2;
    localparam int          CW   = 64;
    localparam int          PW   = 8;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic           clk24 = 1'b0;
    logic           reset = 1'b1;
    logic [31:0]    memory_address = '0;
    logic [31:0]    memory_write_value = '0;
    logic [3:0]     memory_write_sections = '0;
    logic [31:0]    read_value;
    logic           read_valid;
    logic [CH-1:0]  timer_interrupt;
    logic           any_interrupt;

    mmio_timer #(
        .ADDRESS_BASE   (BASE),
        .CHANNEL_COUNT  (CH),
        .COUNTER_WIDTH  (CW),
        .PRESCALE_WIDTH (PW)
    ) dut (
        .clk24                 (clk24),
        .reset                 (reset),
        .memory_address        (memory_address),
        .memory_write_value    (memory_write_value),
        .memory_write_sections (memory_write_sections),
        .read_value            (read_value),
        .read_valid            (read_valid),
        .timer_interrupt       (timer_interrupt),
        .any_interrupt         (any_interrupt)
    );

    always #5 clk24 = ~clk24;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state, register-level view.
    logic [63:0]   m_mtime;
    logic [63:0]   m_cmp [CH];
    logic          m_en;
    logic [CH-1:0] m_ie;
    logic [PW-1:0] m_div;
    int            m_phase;
    logic [CH-1:0] m_match;
    logic [CH-1:0] m_status;
    logic [31:0]   exp_rv;
    logic          exp_valid;
    logic [31:0]   obs_rv;
    logic [31:0]   v0;
    logic [31:0]   v1;

    localparam logic [63:0] CW_MASK = (CW == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CW) - 64'd1);

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] put_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] lanes);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (lanes[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ctrl_image();
        return 32'(m_en) | (32'(m_ie) << 4) | (32'(m_div) << 8);
    endfunction

    function automatic logic [31:0] model_read(input int word);
        int ch;
        if (word == 0)  return m_mtime[31:0];
        if (word == 1)  return m_mtime[63:32];
        if (word == 16) return ctrl_image();
        if (word == 17) return 32'(m_status);
        if (word >= 2 && word <= 9) begin
            ch = (word - 2) / 2;
            if (ch < CH) return (word % 2 == 0) ? m_cmp[ch][31:0] : m_cmp[ch][63:32];
        end
        return 32'd0;
    endfunction

    // Advances the model across one clock edge given this cycle's bus inputs.
    task automatic model_edge(input logic rst, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] lanes);
        bit            hit;
        bit            wr;
        bit            tick;
        int            word;
        int            ch;
        logic [CH-1:0] now_match;
        logic [CH-1:0] clr;
        logic [31:0]   c;
        if (rst) begin
            m_mtime = 0; m_en = 1; m_ie = '1; m_div = 0; m_phase = 0;
            m_match = 0; m_status = 0; exp_rv = 0; exp_valid = 0;
            for (int i = 0; i < CH; i++) m_cmp[i] = CW_MASK;
            return;
        end
        hit       = (addr >= BASE) && ((addr - BASE) < 32'd128);
        word      = int'((addr - BASE) >> 2);
        wr        = hit && (lanes != 4'b0);
        exp_valid = hit;
        exp_rv    = hit ? model_read(word) : 32'd0;

        tick = m_en && (m_phase == int'(m_div));
        for (int i = 0; i < CH; i++) now_match[i] = (m_mtime >= m_cmp[i]);
        clr = '0;
        if (wr && word == 17 && lanes[0]) clr = data[CH-1:0];
        m_status = (now_match & ~m_match) | (m_status & ~clr);
        m_match  = now_match;

        c = ctrl_image();
        if (wr && word == 16) c = put_bytes(c, data, lanes);
        if (wr && word == 16 && c[8 +: PW] != m_div) m_phase = 0;
        else if (m_en) m_phase = tick ? 0 : m_phase + 1;

        if (wr && word == 0)      m_mtime[31:0]  = put_bytes(m_mtime[31:0], data, lanes);
        else if (wr && word == 1) m_mtime[63:32] = put_bytes(m_mtime[63:32], data, lanes);
        else if (tick)            m_mtime = m_mtime + 64'd1;
        m_mtime = m_mtime & CW_MASK;

        if (wr && word >= 2 && word <= 9) begin
            ch = (word - 2) / 2;
            if (ch < CH) begin
                if (word % 2 == 0) m_cmp[ch][31:0]  = put_bytes(m_cmp[ch][31:0], data, lanes);
                else               m_cmp[ch][63:32] = put_bytes(m_cmp[ch][63:32], data, lanes);
                m_cmp[ch] = m_cmp[ch] & CW_MASK;
            end
        end

        m_en  = c[0];
        m_ie  = c[4 +: CH];
        m_div = c[8 +: PW];
    endtask

    task automatic do_cycle(input logic rst, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] lanes);
        reset                 = rst;
        memory_address        = addr;
        memory_write_value    = data;
        memory_write_sections = lanes;
        model_edge(rst, addr, data, lanes);
        @(posedge clk24);
        #1;
        obs_rv = read_value;
        check_value("read_value", read_value, exp_rv);
        check_value("read_valid", read_valid, exp_valid);
        check_value("timer_interrupt", timer_interrupt, m_match & m_ie);
        check_value("any_interrupt", any_interrupt, |(m_match & m_ie));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) do_cycle(1'b1, BASE, 32'hFFFF_FFFF, 4'hF);

        // Counter from reset, one-cycle read latency.
        for (int k = 1; k <= 11; k++) begin
            do_cycle(1'b0, BASE + 32'h00, 32'h0, 4'h0);
            if (k == 1)  check_value("mtime_cycle1", obs_rv, 32'h0);
            if (k == 11) check_value("mtime_cycle11", obs_rv, 32'hA);
        end
        check_value("no_irq_after_reset", {timer_interrupt, any_interrupt}, 0);
        do_cycle(1'b0, 32'h0000_1000, 32'h0, 4'h0);
        check_value("valid_outside", read_valid, 1'b0);

        // Divisor 3 gives one increment per four cycles.
        do_cycle(1'b0, BASE + 32'h40, 32'h0000_0331, 4'b0011);
        do_cycle(1'b0, BASE + 32'h00, 32'h0, 4'h0);
        v0 = obs_rv;
        repeat (39) do_cycle(1'b0, 32'h0, 32'h0, 4'h0);
        do_cycle(1'b0, BASE + 32'h00, 32'h0, 4'h0);
        v1 = obs_rv;
        check_value("div3_advance", 64'(v1 - v0), 64'd10);
        do_cycle(1'b0, BASE + 32'h40, 32'h0000_0031, 4'b0011);
        do_cycle(1'b0, BASE + 32'h00, 32'h0, 4'h0);
        v0 = obs_rv;
        do_cycle(1'b0, BASE + 32'h00, 32'h0, 4'h0);
        check_value("div0_advance", 64'(obs_rv - v0), 64'd1);

        // Wrap from all-ones.
        do_cycle(1'b0, BASE + 32'h0C, 32'h0, 4'hF);
        do_cycle(1'b0, BASE + 32'h08, 32'h5, 4'hF);
        do_cycle(1'b0, BASE + 32'h00, 32'hFFFF_FFFF, 4'hF);
        do_cycle(1'b0, BASE + 32'h04, 32'hFFFF_FFFF, 4'hF);
        do_cycle(1'b0, BASE + 32'h04, 32'h0, 4'h0);
        check_value("mtimeh_all_ones", obs_rv, 32'hFFFF_FFFF);
        check_value("irq0_at_max", timer_interrupt[0], 1'b1);
        do_cycle(1'b0, BASE + 32'h04, 32'h0, 4'h0);
        check_value("mtimeh_wrapped", obs_rv, 32'h0);
        check_value("irq0_after_wrap", timer_interrupt[0], 1'b0);

        // Two channels, only channel 1 enabled.
        repeat (2) do_cycle(1'b1, 32'h0, 32'h0, 4'h0);
        do_cycle(1'b0, BASE + 32'h0C, 32'h0, 4'hF);
        do_cycle(1'b0, BASE + 32'h08, 32'd20, 4'hF);
        do_cycle(1'b0, BASE + 32'h14, 32'h0, 4'hF);
        do_cycle(1'b0, BASE + 32'h10, 32'd30, 4'hF);
        do_cycle(1'b0, BASE + 32'h40, 32'h0000_0021, 4'b0011);
        for (int g = 0; g < 100 && m_mtime != 64'd20; g++)
            do_cycle(1'b0, BASE + 32'h44, 32'h0, 4'h0);
        do_cycle(1'b0, BASE + 32'h44, 32'h1, 4'b0001);
        do_cycle(1'b0, BASE + 32'h44, 32'h0, 4'h0);
        check_value("status_set_wins", obs_rv, 32'h1);
        check_value("ch0_masked", timer_interrupt, 2'b00);
        do_cycle(1'b0, BASE + 32'h44, 32'h1, 4'b0001);
        do_cycle(1'b0, BASE + 32'h44, 32'h0, 4'h0);
        check_value("status_cleared", obs_rv, 32'h0);
        for (int g = 0; g < 100 && m_mtime != 64'd31; g++)
            do_cycle(1'b0, BASE + 32'h00, 32'h0, 4'h0);
        check_value("irq_ch1", timer_interrupt, 2'b10);
        check_value("any_irq", any_interrupt, 1'b1);
        do_cycle(1'b0, BASE + 32'h44, 32'h0, 4'h0);
        check_value("status_ch1", obs_rv, 32'h2);

        // Single byte lane and write-vs-tick.
        do_cycle(1'b0, BASE + 32'h08, 32'h00AB_0000, 4'b0100);
        do_cycle(1'b0, BASE + 32'h08, 32'h0, 4'h0);
        check_value("cmp0_byte2", obs_rv, 32'h00AB_0014);
        do_cycle(1'b0, BASE + 32'h00, 32'h0000_1234, 4'hF);
        do_cycle(1'b0, BASE + 32'h00, 32'h0, 4'h0);
        check_value("mtime_write_holds", obs_rv, 32'h0000_1234);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic [3:0]  l;
            logic        r;
            int          w;
            r = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 9) == 0)
                a = $urandom;
            else
                a = BASE + 32'($urandom_range(0, 31)) * 32'd4 + 32'($urandom_range(0, 3));
            l = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            d = $urandom;
            w = int'((a - BASE) >> 2);
            if (a >= BASE && (a - BASE) < 32'd128) begin
                if (w >= 2 && w <= 9 && w % 2 == 0 && $urandom_range(0, 1) == 1)
                    d = m_mtime[31:0] + 32'($urandom_range(0, 40));
                else if (w >= 1 && w <= 9 && w % 2 == 1 && $urandom_range(0, 3) != 0)
                    d = m_mtime[63:32];
                else if (w == 0 && $urandom_range(0, 1) == 1)
                    l = 4'h0;
                else if (w == 16)
                    d = {16'h0, 8'($urandom_range(0, 3)), 4'($urandom), 3'b000,
                         1'($urandom_range(0, 3) != 0)};
            end
            do_cycle(r, a, d, l);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
